// File: rtl/reset_sequencer.sv
// Staged reset release: PLL lock -> DDR controller -> peripherals -> CPU,
// with calibration timeout/retry and fault-driven resequencing.
module reset_sequencer #(
  parameter int STAGE_DELAY   = 16,
  parameter int CALIB_TIMEOUT = 1048576,
  parameter int MAX_RETRY     = 3
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       pll_locked,
  input  logic       calib_done,
  output logic       mig_rst_n,
  output logic       periph_rst_n,
  output logic       cpu_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt
);

  localparam int CNT_MAX = (STAGE_DELAY > CALIB_TIMEOUT) ? STAGE_DELAY : CALIB_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] CALIB_LAST = CW'(CALIB_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [3:0]    RETRY_MAX  = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    WAIT_CALIB,
    PERIPH_DLY,
    CPU_DLY,
    RUN,
    FAIL
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic          mig_q, mig_d;
  logic          periph_q, periph_d;
  logic          cpu_q, cpu_d;
  logic          ready_q, ready_d;
  logic          fail_q, fail_d;
  logic          fault;

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= WAIT_LOCK;
      cnt_q    <= '0;
      retry_q  <= '0;
      mig_q    <= 1'b0;
      periph_q <= 1'b0;
      cpu_q    <= 1'b0;
      ready_q  <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      mig_q    <= mig_d;
      periph_q <= periph_d;
      cpu_q    <= cpu_d;
      ready_q  <= ready_d;
      fail_q   <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;

    // Lost lock anywhere past WAIT_LOCK, or lost calibration once the DDR is
    // up, restarts the sequence; this overrides any timeout on the same edge.
    fault = (state_q inside {WAIT_CALIB, PERIPH_DLY, CPU_DLY, RUN}) &&
            (!pll_locked || (state_q != WAIT_CALIB && !calib_done));

    case (state_q)
      WAIT_LOCK: begin
        if (!pll_locked) begin
          cnt_d = '0;
        end else if (cnt_q == STAGE_LAST) begin
          state_d = WAIT_CALIB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WAIT_CALIB: begin
        if (calib_done) begin
          state_d = PERIPH_DLY;
          cnt_d   = '0;
        end else if (cnt_q == CALIB_LAST) begin
          cnt_d = '0;
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 4'd1;
            state_d = WAIT_LOCK;
          end else begin
            state_d = FAIL;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PERIPH_DLY: begin
        if (cnt_q == STAGE_LAST) begin
          state_d = CPU_DLY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      CPU_DLY: begin
        if (cnt_q == STAGE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RUN: begin
        cnt_d = '0;
      end
      FAIL: begin
        cnt_d = '0;
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase

    if (fault) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      retry_d = retry_q;
    end

    // Outputs are pure decodes of the next state, so release order holds by construction.
    mig_d    = state_d inside {WAIT_CALIB, PERIPH_DLY, CPU_DLY, RUN};
    periph_d = state_d inside {CPU_DLY, RUN};
    cpu_d    = (state_d == RUN);
    ready_d  = (state_d == RUN);
    fail_d   = (state_d == FAIL);
  end

  assign mig_rst_n    = mig_q;
  assign periph_rst_n = periph_q;
  assign cpu_rst_n    = cpu_q;
  assign ready        = ready_q;
  assign fail         = fail_q;
  assign retry_cnt    = retry_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed, table-driven bench for reset_sequencer with STAGE_DELAY=4,
// CALIB_TIMEOUT=32, MAX_RETRY=2; edge 1 is the first rising edge after release.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       pll_locked = 1'b0;
  logic       calib_done = 1'b0;
  logic       mig_rst_n;
  logic       periph_rst_n;
  logic       cpu_rst_n;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected outputs packed as {mig, periph, cpu, ready, fail, retry_cnt[3:0]}.
  typedef struct {
    int         scen;
    int         edge_n;
    logic       pll;
    logic       calib;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  reset_sequencer #(
    .STAGE_DELAY  (4),
    .CALIB_TIMEOUT(32),
    .MAX_RETRY    (2)
  ) dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .pll_locked  (pll_locked),
    .calib_done  (calib_done),
    .mig_rst_n   (mig_rst_n),
    .periph_rst_n(periph_rst_n),
    .cpu_rst_n   (cpu_rst_n),
    .ready       (ready),
    .fail        (fail),
    .retry_cnt   (retry_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [8:0] pack_exp(logic mig, logic per, logic cpu, logic fl, int retry);
    return {mig, per, cpu, cpu, fl, 4'(retry)};
  endfunction

  function automatic void push(int scen, int e, logic pll, logic calib, logic [8:0] exp);
    vec_t v;
    v.scen   = scen;
    v.edge_n = e;
    v.pll    = pll;
    v.calib  = calib;
    v.exp    = exp;
    vecs.push_back(v);
  endfunction

  function automatic logic [8:0] actual();
    return {mig_rst_n, periph_rst_n, cpu_rst_n, ready, fail, retry_cnt};
  endfunction

  task automatic check(string name, logic [8:0] act, logic [8:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (mig,per,cpu,rdy,fail,retry)", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i      = 1'b0;
    pll_locked = 1'b0;
    calib_done = 1'b0;
    #1;
    check("reset_state", actual(), 9'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic apply_scen(int s, int last_edge);
    foreach (vecs[i]) begin
      if (vecs[i].scen == s && vecs[i].edge_n <= last_edge) begin
        @(negedge clk);
        rst_i      = 1'b1;
        pll_locked = vecs[i].pll;
        calib_done = vecs[i].calib;
        @(posedge clk);
        #1;
        check($sformatf("scen%0d_edge%0d", s, vecs[i].edge_n), actual(), vecs[i].exp);
      end
    end
  endtask

  task automatic async_reset_check(string name);
    #2;
    rst_i = 1'b0;
    #1;
    check(name, actual(), 9'b0);
  endtask

  initial begin
    // Scenario 0: nominal, calib_done from edge 10.
    for (int e = 1; e <= 22; e++)
      push(0, e, 1'b1, e >= 10, pack_exp(e >= 4, e >= 14, e >= 18, 1'b0, 0));

    // Scenario 1: lock glitch at edge 4, then lock drop on the calibration
    // timeout edge 40 (fault wins, no retry), calib_done from edge 45.
    for (int e = 1; e <= 56; e++)
      push(1, e, !(e == 4 || e == 40), e >= 45,
           pack_exp((e >= 8 && e < 40) || e >= 44, e >= 49, e >= 53, 1'b0, 0));

    // Scenario 2: calib_done never arrives; two retries then FAIL at edge 108.
    for (int e = 1; e <= 115; e++)
      push(2, e, 1'b1, 1'b0,
           pack_exp((e >= 4 && e < 36) || (e >= 40 && e < 72) || (e >= 76 && e < 108),
                    1'b0, 1'b0, e >= 108, (e >= 72) ? 2 : (e >= 36) ? 1 : 0));

    // Scenario 3: recovery on the second attempt, then lock drop in RUN at
    // edge 56 and calib_done drop in RUN at edge 72; retry_cnt stays 1.
    for (int e = 1; e <= 88; e++)
      push(3, e, e != 56, e >= 45 && e != 72,
           pack_exp((e >= 4 && e < 36) || (e >= 40 && e < 56) || (e >= 60 && e < 72) || e >= 76,
                    (e >= 49 && e < 56) || (e >= 65 && e < 72) || e >= 81,
                    (e >= 53 && e < 56) || (e >= 69 && e < 72) || e >= 85,
                    1'b0, (e >= 36) ? 1 : 0));

    do_reset();
    apply_scen(0, 22);

    do_reset();
    apply_scen(1, 56);

    do_reset();
    apply_scen(2, 115);
    async_reset_check("async_reset_in_fail");
    repeat (2) @(posedge clk);
    #1;
    check("held_reset_after_fail", actual(), 9'b0);
    apply_scen(0, 22);

    do_reset();
    apply_scen(3, 88);

    do_reset();
    apply_scen(0, 16);
    async_reset_check("async_reset_in_cpu_dly");
    repeat (2) @(posedge clk);
    apply_scen(0, 22);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter STAGE_DELAY, default 16: number of clock edges between successive reset-release stages (legal range 2..65535).
REQ-002 SHALL have parameter CALIB_TIMEOUT, default 1048576: number of clock edges allowed for DDR calibration after mig_rst_n releases (legal range 2..2^24).
REQ-003 SHALL have parameter MAX_RETRY, default 3: number of calibration retries before declaring failure (legal range 0..15).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-low (driven by the synchronized reset output of the upstream reset synchronizer).
REQ-006 SHALL have port pll_locked  input  1  clock generator lock indication, synchronous to clk.
REQ-007 SHALL have port calib_done  input  1  DDR controller calibration-complete indication, synchronous to clk.
REQ-008 SHALL have port mig_rst_n  output  1  active-low reset to DDR controller.
REQ-009 SHALL have port periph_rst_n  output  1  active-low reset to peripherals and bus.
REQ-010 SHALL have port cpu_rst_n  output  1  active-low reset to CPU core.
REQ-011 SHALL have port ready  output  1  sequence complete, system running.
REQ-012 SHALL have port fail  output  1  calibration failed after all retries.
REQ-013 SHALL have port retry_cnt  output  4  number of calibration retries performed.

Function
REQ-014 SHALL drive every output from a register; no combinational path from any input to any output.
REQ-015 SHALL implement states WAIT_LOCK, WAIT_CALIB, PERIPH_DLY, CPU_DLY, RUN, FAIL, with one shared delay/timeout counter of ceil(log2(max(STAGE_DELAY, CALIB_TIMEOUT)))+1 bits.
REQ-016 WAIT_LOCK: counter increments on each edge with pll_locked=1 and clears on any edge with pll_locked=0; at the STAGE_DELAY-th consecutive edge sampling pll_locked=1 -> mig_rst_n=1, counter cleared, go WAIT_CALIB.
REQ-017 WAIT_CALIB: on the first edge sampling calib_done=1 -> counter cleared, go PERIPH_DLY; otherwise counter increments each edge.
REQ-018 WAIT_CALIB timeout: at the CALIB_TIMEOUT-th edge without calib_done -> if retry_cnt < MAX_RETRY: retry_cnt+1, mig_rst_n=0, counter cleared, go WAIT_LOCK; else go FAIL.
REQ-019 PERIPH_DLY: at the STAGE_DELAY-th edge in state -> periph_rst_n=1, counter cleared, go CPU_DLY.
REQ-020 CPU_DLY: at the STAGE_DELAY-th edge in state -> cpu_rst_n=1 and ready=1 on the same edge, go RUN.
REQ-021 RUN: holds all outputs; remains until a fault per REQ-022/023.
REQ-022 pll_locked sampled 0 in any state other than WAIT_LOCK or FAIL -> on that edge mig_rst_n, periph_rst_n, cpu_rst_n, ready all 0, counter cleared, go WAIT_LOCK; retry_cnt unchanged.
REQ-023 calib_done sampled 0 in PERIPH_DLY, CPU_DLY or RUN (pll_locked=1) -> same action as REQ-022; retry_cnt unchanged.
REQ-024 If REQ-022 and a timeout/stage-completion coincide on one edge, REQ-022 wins.
REQ-025 FAIL: mig_rst_n, periph_rst_n, cpu_rst_n, ready = 0, fail=1; terminal until rst_i asserted; inputs ignored.
REQ-026 Release order invariant: cpu_rst_n=1 implies periph_rst_n=1 implies mig_rst_n=1 on every cycle.
REQ-027 retry_cnt saturates at MAX_RETRY and never wraps.

Reset
REQ-028 rst_i=0 SHALL immediately (without clock) force mig_rst_n=0, periph_rst_n=0, cpu_rst_n=0, ready=0, fail=0, retry_cnt=0, counter=0, state WAIT_LOCK.
REQ-029 rst_i asserted mid-sequence (any state incl. RUN, FAIL) SHALL produce the REQ-028 values; sequence restarts from WAIT_LOCK on release.
REQ-030 First state evaluation SHALL occur on the first rising edge with rst_i=1.

Verification (STAGE_DELAY=4, CALIB_TIMEOUT=32, MAX_RETRY=2)
REQ-031 Nominal: pll_locked=1 from release, calib_done=1 at edge 10 -> mig_rst_n=1 at edge 4, periph_rst_n=1 at edge 14, cpu_rst_n=ready=1 at edge 18.
REQ-032 Lock glitch: pll_locked 1,1,1,0,1... -> counter clears; mig_rst_n rises 4 edges after lock returns.
REQ-033 Timeout/retry: calib_done held 0 -> mig_rst_n pulses low twice, retry_cnt=1 then 2, then fail=1 and all resets 0; retry_cnt stays 2.
REQ-034 Recovery: calib_done 0 for first attempt, 1 in second -> retry_cnt=1, ready=1, fail=0.
REQ-035 Fault in RUN: pll_locked drops -> all resets and ready 0 next edge, resequence completes with retry_cnt unchanged; calib_done drop -> same.
REQ-036 Async reset: rst_i=0 mid CPU_DLY and in FAIL -> outputs to reset values before next clk edge; full sequence repeats after release.
